// File: rtl/irq_arbiter.sv
// irq_arbiter: multi-source interrupt controller feeding one vector/ack pair.
// Edge or level sources, enable mask, fixed or round-robin grant, no preemption.
module irq_arbiter #(
  parameter int                 NUM_SRC   = 8,
  parameter int                 VEC_W     = 4,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = {NUM_SRC{1'b1}},
  parameter bit                 RR_MODE   = 1'b0,
  parameter bit                 ACK_EDGE  = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               cfg_we,
  input  logic [NUM_SRC-1:0] cfg_wdata,
  output logic [NUM_SRC-1:0] enable,
  output logic [NUM_SRC-1:0] pending,
  output logic [VEC_W-1:0]   interrupt_vector,
  input  logic               interrupt_ack,
  output logic               irq_any
);
  localparam int NUM_IDX = 2 ** VEC_W;

  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] in_service_q, in_service_d;
  logic [NUM_SRC-1:0] irq_d_q;
  logic               ack_d_q;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [VEC_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic               ack_evt;
  logic               ack_done;
  logic [VEC_W-1:0]   srv_idx;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_IDX-1:0] eligible_ext;
  logic               grant_found;
  logic [VEC_W-1:0]   grant_idx;

  assign rise         = irq_src & ~irq_d_q;
  assign ack_evt      = ACK_EDGE ? (interrupt_ack & ~ack_d_q) : interrupt_ack;
  assign ack_done     = ack_evt & (vec_q != '0);
  assign srv_idx      = vec_q - VEC_W'(1);
  assign eligible     = pending_q & enable_q & ~in_service_q;
  assign eligible_ext = NUM_IDX'(eligible);

  // Candidate index for search step 'off'; round-robin starts at rr_ptr and wraps.
  function automatic logic [VEC_W-1:0] cand_idx(input logic [VEC_W-1:0] start,
                                                input int off);
    int pos;
    pos = off;
    if (RR_MODE) begin
      pos = int'(start) + off;
      if (pos >= NUM_SRC) pos = pos - NUM_SRC;
    end
    return pos[VEC_W-1:0];
  endfunction

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!grant_found && eligible_ext[cand_idx(rr_ptr_q, k)]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    enable_d     = cfg_we ? cfg_wdata : enable_q;
    pending_d    = pending_q;
    in_service_d = in_service_q;
    vec_d        = vec_q;
    rr_ptr_d     = rr_ptr_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (EDGE_MASK[i]) begin
        // A fresh edge in the ack cycle must survive the clear.
        if (ack_done && srv_idx == VEC_W'(i)) pending_d[i] = 1'b0;
        if (rise[i]) pending_d[i] = 1'b1;
        in_service_d[i] = 1'b0;
      end else begin
        pending_d[i] = irq_src[i];
        if (ack_done && srv_idx == VEC_W'(i)) in_service_d[i] = 1'b1;
        else if (!irq_src[i]) in_service_d[i] = 1'b0;
      end
    end
    if (ack_done) begin
      vec_d    = '0;
      rr_ptr_d = (srv_idx == VEC_W'(NUM_SRC - 1)) ? '0 : srv_idx + VEC_W'(1);
    end else if (vec_q == '0 && grant_found) begin
      vec_d = grant_idx + VEC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q     <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      irq_d_q      <= '0;
      ack_d_q      <= 1'b0;
      vec_q        <= '0;
      rr_ptr_q     <= '0;
    end else begin
      enable_q     <= enable_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      irq_d_q      <= irq_src;
      ack_d_q      <= interrupt_ack;
      vec_q        <= vec_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign enable           = enable_q;
  assign pending          = pending_q;
  assign interrupt_vector = vec_q;
  assign irq_any          = |eligible;

endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: scenario tasks with a queue of expected grant vectors.
// dut0 is fixed priority with source 4 level-triggered; dut1 is round-robin.
module tb_irq_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_src;
  logic       cfg_we;
  logic [7:0] cfg_wdata;
  logic       interrupt_ack;

  logic [7:0] enable0, pending0, enable1, pending1;
  logic [3:0] vec0, vec1;
  logic       any0, any1;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  irq_arbiter #(.NUM_SRC(8), .VEC_W(4), .EDGE_MASK(8'hEF), .RR_MODE(1'b0), .ACK_EDGE(1'b1)) dut0 (
    .clk(clk), .reset(reset), .irq_src(irq_src), .cfg_we(cfg_we), .cfg_wdata(cfg_wdata),
    .enable(enable0), .pending(pending0), .interrupt_vector(vec0),
    .interrupt_ack(interrupt_ack), .irq_any(any0));

  irq_arbiter #(.NUM_SRC(8), .VEC_W(4), .EDGE_MASK(8'hFF), .RR_MODE(1'b1), .ACK_EDGE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .irq_src(irq_src), .cfg_we(cfg_we), .cfg_wdata(cfg_wdata),
    .enable(enable1), .pending(pending1), .interrupt_vector(vec1),
    .interrupt_ack(interrupt_ack), .irq_any(any1));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; irq_src = '0; cfg_we = 1'b0; cfg_wdata = '0; interrupt_ack = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic write_enable(input logic [7:0] m);
    cfg_we = 1'b1; cfg_wdata = m;
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic ack_pulse();
    interrupt_ack = 1'b1;
    tick(1);
    interrupt_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; irq_src = 8'hFF; cfg_we = 1'b1; cfg_wdata = 8'hFF; interrupt_ack = 1'b1;
    tick(2);
    checks++; if (enable0 !== 8'h00) begin errors++; $display("FAIL reset_enable got %h want 00", enable0); end
    checks++; if (pending0 !== 8'h00) begin errors++; $display("FAIL reset_pending got %h want 00", pending0); end
    checks++; if (vec0 !== 4'd0) begin errors++; $display("FAIL reset_vector got %0d want 0", vec0); end
    checks++; if (any0 !== 1'b0) begin errors++; $display("FAIL reset_irq_any got %b want 0", any0); end
    checks++; if (vec1 !== 4'd0) begin errors++; $display("FAIL reset_vector_rr got %0d want 0", vec1); end
    do_reset();
  endtask

  task automatic test_basic();
    logic [3:0] exp;
    int nz;
    do_reset();
    write_enable(8'hFF);
    irq_src = 8'h04; exp_q.push_back(4'd3);
    tick(1);
    irq_src = 8'h00;
    checks++; if (pending0 !== 8'h04) begin errors++; $display("FAIL basic_pending got %h want 04", pending0); end
    checks++; if (vec0 !== 4'd0) begin errors++; $display("FAIL basic_early_vector got %0d want 0", vec0); end
    tick(1);
    exp = exp_q.pop_front();
    checks++; if (vec0 !== exp) begin errors++; $display("FAIL basic_vector got %0d want %0d", vec0, exp); end
    interrupt_ack = 1'b1; nz = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (vec0 !== 4'd0) nz++;
    end
    interrupt_ack = 1'b0;
    checks++; if (nz != 0) begin errors++; $display("FAIL basic_ack_hold nonzero_samples %0d want 0", nz); end
    checks++; if (pending0 !== 8'h00) begin errors++; $display("FAIL basic_pending_clr got %h want 00", pending0); end
    tick(3);
    checks++; if (vec0 !== 4'd0) begin errors++; $display("FAIL basic_no_regrant got %0d want 0", vec0); end
  endtask

  task automatic test_fixed();
    logic [3:0] exp;
    int k;
    do_reset();
    write_enable(8'hFF);
    irq_src = 8'h22; exp_q.push_back(4'd2); exp_q.push_back(4'd6);
    tick(1);
    irq_src = 8'h00;
    k = 0; while (vec0 === 4'd0 && k < 8) begin tick(1); k++; end
    exp = exp_q.pop_front();
    checks++; if (vec0 !== exp) begin errors++; $display("FAIL fixed_first got %0d want %0d", vec0, exp); end
    ack_pulse();
    checks++; if (vec0 !== 4'd0) begin errors++; $display("FAIL fixed_idle got %0d want 0", vec0); end
    tick(1);
    exp = exp_q.pop_front();
    checks++; if (vec0 !== exp) begin errors++; $display("FAIL fixed_second got %0d want %0d", vec0, exp); end
    ack_pulse();
    checks++; if (pending0 !== 8'h00) begin errors++; $display("FAIL fixed_pending_clr got %h want 00", pending0); end
    tick(2);
    checks++; if (vec0 !== 4'd0) begin errors++; $display("FAIL fixed_final_idle got %0d want 0", vec0); end
  endtask

  task automatic test_rr();
    logic [3:0] exp;
    int k, s;
    do_reset();
    write_enable(8'hFF);
    irq_src = 8'h0B;
    tick(1);
    irq_src = 8'h00;
    repeat (2) begin exp_q.push_back(4'd1); exp_q.push_back(4'd2); exp_q.push_back(4'd4); end
    for (int n = 0; n < 6; n++) begin
      k = 0; while (vec1 === 4'd0 && k < 8) begin tick(1); k++; end
      exp = exp_q.pop_front();
      checks++; if (vec1 !== exp) begin errors++; $display("FAIL rr_order step %0d got %0d want %0d", n, vec1, exp); end
      s = int'(vec1) - 1;
      ack_pulse();
      if (s >= 0 && s < 8) begin
        irq_src[s] = 1'b1;
        tick(1);
        irq_src = 8'h00;
      end
    end
  endtask

  task automatic test_level();
    logic [3:0] exp;
    int k, nz, an;
    do_reset();
    write_enable(8'hFF);
    irq_src = 8'h10; exp_q.push_back(4'd5);
    k = 0; while (vec0 === 4'd0 && k < 8) begin tick(1); k++; end
    exp = exp_q.pop_front();
    checks++; if (vec0 !== exp) begin errors++; $display("FAIL level_grant got %0d want %0d", vec0, exp); end
    ack_pulse();
    nz = 0; an = 0;
    for (int j = 0; j < 5; j++) begin
      if (vec0 !== 4'd0) nz++;
      if (any0 !== 1'b0) an++;
      tick(1);
    end
    checks++; if (nz != 0) begin errors++; $display("FAIL level_no_storm nonzero_samples %0d want 0", nz); end
    checks++; if (an != 0) begin errors++; $display("FAIL level_irq_any_in_service samples %0d want 0", an); end
    checks++; if (pending0[4] !== 1'b1) begin errors++; $display("FAIL level_pending got %b want 1", pending0[4]); end
    irq_src = 8'h00;
    tick(1);
    irq_src = 8'h10; exp_q.push_back(4'd5);
    k = 0; while (vec0 === 4'd0 && k < 8) begin tick(1); k++; end
    exp = exp_q.pop_front();
    checks++; if (vec0 !== exp) begin errors++; $display("FAIL level_regrant got %0d want %0d", vec0, exp); end
    ack_pulse();
    irq_src = 8'h00;
  endtask

  task automatic test_enable();
    logic [3:0] exp;
    do_reset();
    irq_src = 8'h40;
    tick(1);
    irq_src = 8'h00;
    checks++; if (pending0 !== 8'h40) begin errors++; $display("FAIL enable_pending got %h want 40", pending0); end
    tick(3);
    checks++; if (vec0 !== 4'd0) begin errors++; $display("FAIL enable_gated got %0d want 0", vec0); end
    checks++; if (any0 !== 1'b0) begin errors++; $display("FAIL enable_irq_any got %b want 0", any0); end
    exp_q.push_back(4'd7);
    write_enable(8'h40);
    checks++; if (enable0 !== 8'h40) begin errors++; $display("FAIL enable_write got %h want 40", enable0); end
    checks++; if (vec0 !== 4'd0) begin errors++; $display("FAIL enable_one_cycle got %0d want 0", vec0); end
    tick(1);
    exp = exp_q.pop_front();
    checks++; if (vec0 !== exp) begin errors++; $display("FAIL enable_grant got %0d want %0d", vec0, exp); end
    write_enable(8'h00);
    tick(2);
    checks++; if (vec0 !== 4'd7) begin errors++; $display("FAIL enable_no_preempt got %0d want 7", vec0); end
    checks++; if (pending0 !== 8'h40) begin errors++; $display("FAIL enable_keep_pending got %h want 40", pending0); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    int k;
    do_reset();
    write_enable(8'hFF);
    irq_src = 8'h08; exp_q.push_back(4'd4);
    tick(1);
    irq_src = 8'h00;
    k = 0; while (vec0 === 4'd0 && k < 8) begin tick(1); k++; end
    exp = exp_q.pop_front();
    checks++; if (vec0 !== exp) begin errors++; $display("FAIL collide_first got %0d want %0d", vec0, exp); end
    interrupt_ack = 1'b1; irq_src = 8'h08;
    tick(1);
    interrupt_ack = 1'b0; irq_src = 8'h00;
    checks++; if (vec0 !== 4'd0) begin errors++; $display("FAIL collide_idle got %0d want 0", vec0); end
    checks++; if (pending0[3] !== 1'b1) begin errors++; $display("FAIL collide_pending got %b want 1", pending0[3]); end
    exp_q.push_back(4'd4);
    tick(1);
    exp = exp_q.pop_front();
    checks++; if (vec0 !== exp) begin errors++; $display("FAIL collide_regrant got %0d want %0d", vec0, exp); end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++; if (vec0 !== 4'd0) begin errors++; $display("FAIL midreset_vector got %0d want 0", vec0); end
    checks++; if (pending0 !== 8'h00) begin errors++; $display("FAIL midreset_pending got %h want 00", pending0); end
  endtask

  initial begin
    reset = 1'b1; irq_src = '0; cfg_we = 1'b0; cfg_wdata = '0; interrupt_ack = 1'b0;
    test_reset();
    test_basic();
    test_fixed();
    test_rr();
    test_level();
    test_enable();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Multi-source interrupt controller between board peripherals (PS/2 keyboard, UART, timer, future) and the riscv64 core's interrupt_vector/interrupt_ack pins.
- Generalises the single-source, raise-until-ack scheme to NUM_SRC channels:
  - per-source edge/level mode,
  - enable mask,
  - fixed or round-robin priority,
  - ack edge-qualification so a slow-clocked CPU can hold ack for many cycles.

Parameters:
- NUM_SRC, 8, number of interrupt sources, 1..15.
- VEC_W, 4, vector width; requires 2**VEC_W > NUM_SRC; vector value 0 = none.
- EDGE_MASK, 8'hFF, per-source mode; bit=1 rising-edge triggered, bit=0 level-high.
- RR_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.
- ACK_EDGE, 1, 1 = act on rising edge of interrupt_ack only; 0 = act on every cycle ack is high.

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset  in  1  synchronous, active-high reset
- irq_src  in  NUM_SRC  interrupt requests, already synchronous to clk
- cfg_we  in  1  write strobe for enable mask
- cfg_wdata  in  NUM_SRC  new enable mask
- enable  out  NUM_SRC  current enable mask
- pending  out  NUM_SRC  pending bits (bus-readable)
- interrupt_vector  out  VEC_W  served source id+1; 0 = idle
- interrupt_ack  in  1  CPU acknowledge
- irq_any  out  1  OR of (pending & enable & ~in_service)

Behaviour:
- Reset (clk edge with reset=1) clears enable, pending, in_service, irq_d, ack_d, the RR pointer and interrupt_vector; irq_any=0. Reset mid-handshake drops the vector to 0 immediately on the next edge.
- irq_d is the registered copy of irq_src; ack_d is the registered copy of interrupt_ack.
- Edge source i:
  - pending[i] sets on the edge where irq_src[i] & ~irq_d[i].
  - Pending latches regardless of enable; enable only gates arbitration.
- Level source i:
  - pending[i] = registered irq_src[i].
  - in_service[i] sets on ack of source i and clears on the first edge where irq_src[i] is sampled 0.
  - Eligible only when pending & ~in_service, which prevents an ack storm while the device is still asserting.
- Latency: irq_src rises before edge T; pending visible after T; interrupt_vector visible after T+1, i.e. 2 cycles.
- Arbitration runs only when interrupt_vector==0 and no ack-completion happened in the previous cycle.
  - Eligible set = pending & enable & ~in_service.
  - RR_MODE=0: lowest index wins.
  - RR_MODE=1: search starts at last_served+1 and wraps modulo NUM_SRC; last_served updates on ack.
  - Winner w drives interrupt_vector = w+1 (zero-extended to VEC_W).
- No preemption: a nonzero vector is held stable until acked, even if a higher-priority source becomes pending or the served source is disabled.
- Ack qualifier: ack_evt = interrupt_ack & ~ack_d when ACK_EDGE=1, else interrupt_ack.
- On ack_evt with vector=w+1:
  - Next edge: vector -> 0.
  - Edge source: pending[w] cleared.
  - Level source: in_service[w] set.
  - Vector stays 0 for at least one full cycle before the next grant.
- ack_evt while vector==0 is ignored; no state change.
- Simultaneous new edge on w and ack of w: pending[w] stays 1 (new event wins), and w is re-served later.
- cfg_we writes enable on the next edge.
  - Disabling a pending source keeps its pending bit.
  - Re-enabling makes it eligible again.
  - Writes never touch pending.
- Widths: vector computed as unsigned NUM_SRC-index + 1; VEC_W truncation never occurs given the parameter rule.

Test Plan:
- Reset, enable=8'hFF, pulse irq_src[2] for 1 cycle -> pending=8'h04 after 1 cycle, vector=3 after 2 cycles; hold ack high 10 cycles -> vector=0 once, pending=0, no re-grant.
- Fixed priority: irq_src[5] and irq_src[1] edges in the same cycle -> vector=2; ack -> one idle cycle, then vector=6; ack -> vector 0, pending=0.
- RR_MODE=1: sources 0, 1, 3 held pending repeatedly -> grant order 1, 2, 4, 1, 2, 4 (vectors) across successive acks.
- Level source (EDGE_MASK bit 4=0): irq_src[4] held high -> vector=5; ack -> vector 0 and no re-grant while high; drop low for 1 cycle then raise -> vector=5 again.
- Enable mask: enable=8'h00, edge on src 6 -> pending[6]=1, vector stays 0; write enable=8'h40 -> vector=7 two cycles after the write.
- Edge on src 3 in the same cycle as ack of src 3 -> pending[3] remains 1, vector=4 re-presented after the idle cycle; reset asserted while vector nonzero -> vector=0, pending=0 next edge.
